// File: rtl/baud_ctrl_if.sv
// ============================================================================
//  Module      : baud_ctrl_if
//  Description : Rate-change handshake and tick outputs of the baud controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface baud_ctrl_if;
    logic [1:0] cfg_sel;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       line_busy;
    logic       tick;
    logic       bit_tick;
    logic [1:0] cur_sel;
    logic       chg_done;

    modport master (
        output cfg_sel, cfg_valid, line_busy,
        input  cfg_ready, tick, bit_tick, cur_sel, chg_done
    );

    modport slave (
        input  cfg_sel, cfg_valid, line_busy,
        output cfg_ready, tick, bit_tick, cur_sel, chg_done
    );
endinterface

`default_nettype wire

// File: rtl/baud_ctrl.sv
// ============================================================================
//  Module      : baud_ctrl
//  Description : UART 16x oversample tick generator with a four-entry divisor
//                table; rate changes wait for an idle line before reloading.
//                Define BAUD_CTRL_BITTICK_EN to enable the per-bit tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_ctrl #(
    parameter int N         = 10,
    parameter int DIV0      = 651,
    parameter int DIV1      = 326,
    parameter int DIV2      = 109,
    parameter int DIV3      = 54,
    parameter int RESET_SEL = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    baud_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    // Terminal counts; a divisor of 2^N wraps to all-ones in N bits.
    localparam logic [N-1:0] c_DIV0_M1  = N'(DIV0 - 1);
    localparam logic [N-1:0] c_DIV1_M1  = N'(DIV1 - 1);
    localparam logic [N-1:0] c_DIV2_M1  = N'(DIV2 - 1);
    localparam logic [N-1:0] c_DIV3_M1  = N'(DIV3 - 1);
    localparam logic [1:0]   c_RST_SEL  = 2'(RESET_SEL);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_count;
    logic [1:0]     r_cur_sel;
    logic [1:0]     r_pend_sel;
    logic           r_chg_done;
    logic [N-1:0]   w_div_m1;
    logic           w_reload;
    logic           w_tick;
    logic           w_accept;

    always_comb begin
        w_div_m1 = c_DIV0_M1;
        case (r_cur_sel)
            2'd0:    w_div_m1 = c_DIV0_M1;
            2'd1:    w_div_m1 = c_DIV1_M1;
            2'd2:    w_div_m1 = c_DIV2_M1;
            default: w_div_m1 = c_DIV3_M1;
        endcase
    end

    assign w_reload = (r_state == ST_RELOAD);
    assign w_tick   = (r_count == w_div_m1) & ~w_reload;
    assign w_accept = bus.cfg_valid & (r_state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_accept)       w_state_nxt = ST_PEND;
            ST_PEND:   if (!bus.line_busy) w_state_nxt = ST_RELOAD;
            ST_RELOAD: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_cur_sel  <= c_RST_SEL;
            r_pend_sel <= c_RST_SEL;
            r_chg_done <= 1'b0;
        end else begin
            r_chg_done <= w_reload;
            if (w_accept) begin
                r_pend_sel <= bus.cfg_sel;
            end
            // Reload restarts the phase even when the rate index is unchanged.
            if (w_reload) begin
                r_count   <= '0;
                r_cur_sel <= r_pend_sel;
            end else if (r_count == w_div_m1) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

`ifdef BAUD_CTRL_BITTICK_EN
    logic [3:0] r_tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= 4'd0;
        end else if (w_reload) begin
            r_tcnt <= 4'd0;
        end else if (w_tick) begin
            r_tcnt <= r_tcnt + 4'd1;
        end
    end

    assign bus.bit_tick = w_tick & (r_tcnt == 4'd15);
`else
    assign bus.bit_tick = 1'b0;
`endif

    assign bus.tick      = w_tick;
    assign bus.cfg_ready = (r_state == ST_RUN);
    assign bus.cur_sel   = r_cur_sel;
    assign bus.chg_done  = r_chg_done;

endmodule

`default_nettype wire

// File: tb/tb_baud_ctrl.sv
// ============================================================================
//  Module      : tb_baud_ctrl
//  Description : Scoreboard bench for baud_ctrl (DIV 4/6/3/2, RESET_SEL 0).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baud_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    baud_ctrl_if bif ();

    baud_ctrl #(
        .N(10), .DIV0(4), .DIV1(6), .DIV2(3), .DIV3(2), .RESET_SEL(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic bt; }              tick_t;
    typedef struct { int cyc; logic [1:0] sel; }       chg_t;
    typedef struct { int cyc; int kind; logic [1:0] exp; } lvl_t;

    tick_t tick_q[$];
    chg_t  chg_q[$];
    lvl_t  lvl_q[$];

    int checks = 0;
    int errors = 0;
    bit done_req = 1'b0;

    // Expected tick schedule
    int next_tick  = 0;
    int period     = 4;
    int tidx       = 0;
    int reload_cyc = -1;
    int new_period = 4;
    bit in_rst     = 1'b1;

    // ------------------------------------------------------------------ monitor
    always @(negedge clk) begin
        tick_t te;
        chg_t  ce;
        lvl_t  le;
        logic [1:0] act;
        if (!rst) begin
            if (bif.tick) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected cycle %0d: got tick=1 want none", cyc);
                end else begin
                    te = tick_q.pop_front();
                    if (te.cyc != cyc || te.bt !== bif.bit_tick) begin
                        errors++;
                        $display("FAIL tick cycle got %0d want %0d, bit_tick got %0b want %0b",
                                 cyc, te.cyc, bif.bit_tick, te.bt);
                    end
                end
            end else begin
                checks++;
                if (bif.bit_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL bit_tick_gate cycle %0d: got %0b want 0", cyc, bif.bit_tick);
                end
                if (tick_q.size() > 0 && tick_q[0].cyc <= cyc) begin
                    errors++;
                    $display("FAIL tick_missing got none at cycle %0d want tick at %0d", cyc, tick_q[0].cyc);
                    void'(tick_q.pop_front());
                end
            end

            if (bif.chg_done) begin
                checks++;
                if (chg_q.size() == 0) begin
                    errors++;
                    $display("FAIL chg_unexpected cycle %0d: got chg_done=1 want none", cyc);
                end else begin
                    ce = chg_q.pop_front();
                    if (ce.cyc != cyc || ce.sel !== bif.cur_sel) begin
                        errors++;
                        $display("FAIL chg_done got cycle %0d sel %0d want cycle %0d sel %0d",
                                 cyc, bif.cur_sel, ce.cyc, ce.sel);
                    end
                end
            end else if (chg_q.size() > 0 && chg_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL chg_missing got none at cycle %0d want at %0d", cyc, chg_q[0].cyc);
                void'(chg_q.pop_front());
            end

            while (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
                le = lvl_q.pop_front();
                case (le.kind)
                    0:       act = {1'b0, bif.cfg_ready};
                    1:       act = bif.cur_sel;
                    default: act = {1'b0, bif.chg_done};
                endcase
                checks++;
                if (act !== le.exp) begin
                    errors++;
                    $display("FAIL level_%s cycle %0d: got %0d want %0d",
                             (le.kind == 0) ? "cfg_ready" : (le.kind == 1) ? "cur_sel" : "chg_done",
                             cyc, act, le.exp);
                end
            end
        end

        if (done_req) begin
            checks++;
            if (tick_q.size() != 0 || chg_q.size() != 0 || lvl_q.size() != 0) begin
                errors++;
                $display("FAIL queues_drained got tick=%0d chg=%0d lvl=%0d pending want 0",
                         tick_q.size(), chg_q.size(), lvl_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // ------------------------------------------------------------------ helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit();
        tick_t e;
        if (cyc == reload_cyc) begin
            period     = new_period;
            next_tick  = cyc + new_period;
            tidx       = 0;
            reload_cyc = -1;
        end
        if (!in_rst) begin
            while (next_tick <= cyc) begin
                e.cyc = next_tick;
`ifdef BAUD_CTRL_BITTICK_EN
                e.bt  = (tidx == 15);
`else
                e.bt  = 1'b0;
`endif
                tick_q.push_back(e);
                tidx      = (tidx + 1) % 16;
                next_tick = next_tick + period;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            commit();
        end
    endtask

    task automatic expect_lvl(input int kind, input logic [1:0] exp);
        lvl_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = exp;
        lvl_q.push_back(e);
    endtask

    task automatic expect_chg(input int c, input logic [1:0] sel);
        chg_t e;
        e.cyc = c;
        e.sel = sel;
        chg_q.push_back(e);
    endtask

    task automatic release_rst();
        rst        = 1'b0;
        in_rst     = 1'b0;
        period     = 4;
        next_tick  = cyc + 3;
        tidx       = 0;
        reload_cyc = -1;
    endtask

    // ------------------------------------------------------------------ stimulus
    initial begin
        rst           = 1'b1;
        bif.cfg_valid = 1'b0;
        bif.cfg_sel   = 2'd0;
        bif.line_busy = 1'b0;
        repeat (3) step();

        // Reset release, free-running at period 4
        release_rst();
        expect_lvl(0, 2'd1);
        expect_lvl(1, 2'd0);
        expect_lvl(2, 2'd0);
        commit();
        idle(70);

        // Change to sel 1 on an idle line
        step();
        bif.cfg_sel   = 2'd1;
        bif.cfg_valid = 1'b1;
        expect_lvl(0, 2'd1);
        reload_cyc = cyc + 2;
        new_period = 6;
        expect_chg(cyc + 3, 2'd1);
        commit();
        step(); bif.cfg_valid = 1'b0; expect_lvl(0, 2'd0); commit();
        step(); expect_lvl(0, 2'd0); commit();
        step(); expect_lvl(0, 2'd1); expect_lvl(1, 2'd1); expect_lvl(2, 2'd1); commit();
        idle(20);

        // Change to sel 2 held off by a busy line; sel 3 pulse in PEND is ignored
        step();
        bif.line_busy = 1'b1;
        bif.cfg_sel   = 2'd2;
        bif.cfg_valid = 1'b1;
        expect_lvl(0, 2'd1);
        commit();
        step(); bif.cfg_valid = 1'b0; expect_lvl(0, 2'd0); commit();
        idle(5);
        step(); bif.cfg_sel = 2'd3; bif.cfg_valid = 1'b1; expect_lvl(0, 2'd0); commit();
        step(); bif.cfg_valid = 1'b0; expect_lvl(1, 2'd1); commit();
        idle(12);
        // Drop busy in a cycle that carries an old-rate tick
        while (next_tick != cyc + 1) begin
            step();
            commit();
        end
        step();
        bif.line_busy = 1'b0;
        reload_cyc = cyc + 1;
        new_period = 3;
        expect_chg(cyc + 2, 2'd2);
        commit();
        idle(3);
        step(); expect_lvl(1, 2'd2); commit();
        idle(12);

        // Back to sel 0
        step();
        bif.cfg_sel   = 2'd0;
        bif.cfg_valid = 1'b1;
        reload_cyc = cyc + 2;
        new_period = 4;
        expect_chg(cyc + 3, 2'd0);
        commit();
        step(); bif.cfg_valid = 1'b0; commit();
        idle(10);

        // Same-rate request issued at count == 2 resyncs the phase
        step();
        while (next_tick != cyc + 1) begin
            commit();
            step();
        end
        bif.cfg_sel   = 2'd0;
        bif.cfg_valid = 1'b1;
        expect_lvl(1, 2'd0);
        reload_cyc = cyc + 2;
        new_period = 4;
        expect_chg(cyc + 3, 2'd0);
        commit();
        step(); bif.cfg_valid = 1'b0; commit();
        idle(12);

        // Reset while pending discards the request
        step();
        bif.line_busy = 1'b1;
        bif.cfg_sel   = 2'd1;
        bif.cfg_valid = 1'b1;
        commit();
        step(); bif.cfg_valid = 1'b0; commit();
        idle(3);
        step();
        rst        = 1'b1;
        in_rst     = 1'b1;
        reload_cyc = -1;
        commit();
        idle(2);
        step();
        release_rst();
        expect_lvl(0, 2'd1);
        expect_lvl(1, 2'd0);
        expect_lvl(2, 2'd0);
        commit();
        step(); bif.line_busy = 1'b0; commit();
        idle(30);
        step(); expect_lvl(1, 2'd0); expect_lvl(0, 2'd1); commit();

        done_req = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL summary_not_reached got no summary want summary");
        $fatal(1);
    end

endmodule

`default_nettype wire
